// File: rtl/ptr_pkg.sv
// Shared constants and the per-channel operation encoding for the pointer bank.
package ptr_pkg;

  localparam int PTR_DEFAULT_WIDTH = 8;
  localparam int PTR_DEFAULT_NCH   = 4;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } ptr_op_e;

endpackage

// File: rtl/ptr_cell.sv
// One pointer channel: pointer, limit and wrap flop with priority decode.
// Decrement support is compiled in only when PTR_DEC_EN is defined.
module ptr_cell
  import ptr_pkg::*;
#(
  parameter int WIDTH = PTR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic             wen,
  input  logic             lim_wen,
  input  logic             clr,
  input  logic             inc,
`ifdef PTR_DEC_EN
  input  logic             dec,
`endif
  output logic [WIDTH-1:0] ptr,
  output logic             at_lim,
  output logic             wrap
);

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             wrap_q, wrap_d;
  ptr_op_e          op;

  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (wen) begin
      op = OP_LOAD;
`ifdef PTR_DEC_EN
    end else if (inc && !dec) begin
      op = OP_INC;
    end else if (dec && !inc) begin
      op = OP_DEC;
`else
    end else if (inc) begin
      op = OP_INC;
`endif
    end
  end

  // Increment/decrement compare against the old limit, so a same-cycle
  // limit write only affects the following cycles.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    lim_d  = lim_wen ? bus : lim_q;
    case (op)
      OP_CLR:  ptr_d = '0;
      OP_LOAD: ptr_d = bus;
      OP_INC: begin
        if (ptr_q == lim_q || ptr_q == '1) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      OP_DEC: begin
        if (ptr_q == '0) begin
          ptr_d  = lim_q;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      lim_q  <= '1;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lim_q  <= lim_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr    = ptr_q;
  assign at_lim = (ptr_q == lim_q);
  assign wrap   = wrap_q;

endmodule

// File: rtl/ptr_bank.sv
// Bank of NCH independent address pointers with read mux and flat output.
// Define PTR_DEC_EN to add the DEC port and decrement behaviour.
module ptr_bank
  import ptr_pkg::*;
#(
  parameter int WIDTH = PTR_DEFAULT_WIDTH,
  parameter int NCH   = PTR_DEFAULT_NCH,
  parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     BusOut,
  input  logic [NCH-1:0]       Wen,
  input  logic [NCH-1:0]       LimWen,
  input  logic [NCH-1:0]       CLR,
  input  logic [NCH-1:0]       INC,
`ifdef PTR_DEC_EN
  input  logic [NCH-1:0]       DEC,
`endif
  input  logic [SEL_W-1:0]     Sel,
  output logic [WIDTH-1:0]     dout,
  output logic [NCH*WIDTH-1:0] ptr_flat,
  output logic [NCH-1:0]       at_lim,
  output logic [NCH-1:0]       wrap
);

  logic [WIDTH-1:0] ptr_arr [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ptr_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (Clk),
      .rst    (RST),
      .bus    (BusOut),
      .wen    (Wen[gi]),
      .lim_wen(LimWen[gi]),
      .clr    (CLR[gi]),
      .inc    (INC[gi]),
`ifdef PTR_DEC_EN
      .dec    (DEC[gi]),
`endif
      .ptr    (ptr_arr[gi]),
      .at_lim (at_lim[gi]),
      .wrap   (wrap[gi])
    );
    assign ptr_flat[gi*WIDTH +: WIDTH] = ptr_arr[gi];
  end

  // Select values with no matching channel fall through to zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(Sel) == i) dout = ptr_arr[i];
    end
  end

endmodule

// File: tb/tb_ptr_bank.sv
// Self-checking bench for ptr_bank with a behavioural reference model.
// Decrement scenarios are exercised when PTR_DEC_EN is defined.
module tb_ptr_bank;

  localparam int W = 8;
  localparam int N = 4;
  localparam int MAXV = 255;

  logic         Clk = 1'b0;
  logic         RST;
  logic [W-1:0] BusOut;
  logic [N-1:0] Wen, LimWen, CLR, INC, DEC;
  logic [1:0]   Sel;
  logic [W-1:0] dout;
  logic [N*W-1:0] ptr_flat;
  logic [N-1:0] at_lim, wrap;

  int errors = 0;
  int checks = 0;

  int m_ptr [N];
  int m_lim [N];
  int m_wrap[N];

  always #5 Clk = ~Clk;

  ptr_bank dut (
    .Clk(Clk), .RST(RST), .BusOut(BusOut), .Wen(Wen), .LimWen(LimWen),
    .CLR(CLR), .INC(INC),
`ifdef PTR_DEC_EN
    .DEC(DEC),
`endif
    .Sel(Sel), .dout(dout), .ptr_flat(ptr_flat), .at_lim(at_lim), .wrap(wrap)
  );

  // Reference: apply one clock edge worth of the channel rules.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int up, down, nxt, nw;
      up = INC[i];
`ifdef PTR_DEC_EN
      down = DEC[i];
`else
      down = 0;
`endif
      nxt = m_ptr[i];
      nw  = 0;
      if (RST) begin
        m_ptr[i] = 0; m_lim[i] = MAXV; m_wrap[i] = 0;
        continue;
      end
      if (CLR[i]) nxt = 0;
      else if (Wen[i]) nxt = BusOut;
      else if (up && !down) begin
        if (m_ptr[i] == m_lim[i] || m_ptr[i] == MAXV) begin nxt = 0; nw = 1; end
        else nxt = m_ptr[i] + 1;
      end else if (down && !up) begin
        if (m_ptr[i] == 0) begin nxt = m_lim[i]; nw = 1; end
        else nxt = m_ptr[i] - 1;
      end
      m_ptr[i]  = nxt;
      m_wrap[i] = nw;
      if (LimWen[i]) m_lim[i] = BusOut;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] w, input logic [N-1:0] lw,
                      input logic [N-1:0] c, input logic [N-1:0] inc_v,
                      input logic [N-1:0] dec_v, input logic [W-1:0] b);
    RST = r; Wen = w; LimWen = lw; CLR = c; INC = inc_v; DEC = dec_v; BusOut = b;
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0, '0, '0, '0, 8'h00);
    step(1'b1, '0, '0, '0, '0, '0, 8'h00);
    for (int i = 0; i < N; i++) begin
      Sel = 2'(i);
      #1;
      checks++;
      if (dout !== 8'd0 || ptr_flat[i*W +: W] !== 8'd0 || wrap[i] !== 1'b0 || at_lim[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset ch%0d: dout=%0d ptr=%0d wrap=%b at_lim=%b, required 0/0/0/0",
                 i, dout, ptr_flat[i*W +: W], wrap[i], at_lim[i]);
      end
    end
    step(1'b0, '0, '0, '0, '0, '0, 8'h00);
  endtask

  task automatic test_inc_full_range();
    int pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      step(1'b0, '0, '0, '0, 4'b0001, '0, 8'h00);
      if (wrap[0]) pulses++;
      checks++;
      if (ptr_flat[7:0] !== 8'(k % 256) || wrap[0] !== (k == 256)) begin
        errors++;
        $display("FAIL inc_range step %0d: ptr0=%0d wrap0=%b, required %0d/%b",
                 k, ptr_flat[7:0], wrap[0], k % 256, (k == 256));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL inc_range pulses: got %0d, required 1", pulses);
    end
    step(1'b0, '0, '0, '0, '0, '0, 8'h00);
    checks++;
    if (wrap[0] !== 1'b0) begin
      errors++;
      $display("FAIL inc_range wrap_clear: wrap0=%b, required 0", wrap[0]);
    end
  endtask

  task automatic test_limit_wrap();
    int exp_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int prev = 0;
    step(1'b0, '0, 4'b0010, '0, '0, '0, 8'd3);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, '0, '0, 4'b0010, '0, 8'h00);
      checks++;
      if (ptr_flat[15:8] !== 8'(exp_seq[k]) || wrap[1] !== (prev == 3) ||
          at_lim[1] !== (exp_seq[k] == 3)) begin
        errors++;
        $display("FAIL limit_wrap step %0d: ptr1=%0d wrap1=%b at_lim1=%b, required %0d/%b/%b",
                 k, ptr_flat[15:8], wrap[1], at_lim[1], exp_seq[k], (prev == 3), (exp_seq[k] == 3));
      end
      prev = exp_seq[k];
    end
  endtask

  task automatic test_priority();
    Sel = 2'd2;
    step(1'b0, 4'b0100, '0, '0, 4'b0100, '0, 8'd25);
    checks++;
    if (dout !== 8'd25 || ptr_flat[23:16] !== 8'd25 || wrap[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: dout=%0d ptr2=%0d wrap2=%b, required 25/25/0",
               dout, ptr_flat[23:16], wrap[2]);
    end
    step(1'b0, '0, '0, 4'b0100, 4'b0100, '0, 8'd99);
    checks++;
    if (dout !== 8'd0 || ptr_flat[23:16] !== 8'd0 || wrap[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins: dout=%0d ptr2=%0d wrap2=%b, required 0/0/0",
               dout, ptr_flat[23:16], wrap[2]);
    end
  endtask

  task automatic test_above_limit_and_reset();
    step(1'b0, '0, 4'b1000, '0, '0, '0, 8'd10);
    step(1'b0, 4'b1000, '0, '0, '0, '0, 8'd75);
    for (int v = 76; v <= 256; v++) begin
      step(1'b0, '0, '0, '0, 4'b1000, '0, 8'h00);
      checks++;
      if (ptr_flat[31:24] !== 8'(v % 256) || wrap[3] !== (v == 256)) begin
        errors++;
        $display("FAIL above_lim v=%0d: ptr3=%0d wrap3=%b, required %0d/%b",
                 v, ptr_flat[31:24], wrap[3], v % 256, (v == 256));
      end
    end
    // wrap[3] is high here; reset must clear it and restore the limit
    step(1'b1, '0, '0, '0, 4'b1000, '0, 8'h00);
    checks++;
    if (ptr_flat[31:24] !== 8'd0 || wrap[3] !== 1'b0 || at_lim[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ptr3=%0d wrap3=%b at_lim3=%b, required 0/0/0",
               ptr_flat[31:24], wrap[3], at_lim[3]);
    end
    step(1'b0, 4'b1000, '0, '0, '0, '0, 8'd10);
    step(1'b0, '0, '0, '0, 4'b1000, '0, 8'h00);
    checks++;
    if (ptr_flat[31:24] !== 8'd11 || wrap[3] !== 1'b0) begin
      errors++;
      $display("FAIL limit_restored: ptr3=%0d wrap3=%b, required 11/0", ptr_flat[31:24], wrap[3]);
    end
  endtask

  task automatic test_all_channels();
    logic [7:0] lims [N] = '{8'd2, 8'd5, 8'd0, 8'd7};
    step(1'b0, '0, '0, 4'b1111, '0, '0, 8'h00);
    for (int i = 0; i < N; i++) step(1'b0, '0, 4'(1 << i), '0, '0, '0, lims[i]);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, '0, '0, 4'b1111, '0, 8'h00);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ptr_flat[i*W +: W] !== 8'(m_ptr[i]) || wrap[i] !== 1'(m_wrap[i]) ||
            at_lim[i] !== (m_ptr[i] == m_lim[i])) begin
          errors++;
          $display("FAIL all_ch k=%0d ch%0d: ptr=%0d wrap=%b at_lim=%b, required %0d/%0d/%0d",
                   k, i, ptr_flat[i*W +: W], wrap[i], at_lim[i], m_ptr[i], m_wrap[i],
                   (m_ptr[i] == m_lim[i]));
        end
      end
    end
  endtask

`ifdef PTR_DEC_EN
  task automatic test_dec();
    step(1'b0, '0, 4'b0001, 4'b0001, '0, '0, 8'd62);
    step(1'b0, '0, '0, '0, '0, 4'b0001, 8'h00);
    checks++;
    if (ptr_flat[7:0] !== 8'd62 || wrap[0] !== 1'b1) begin
      errors++;
      $display("FAIL dec_wrap: ptr0=%0d wrap0=%b, required 62/1", ptr_flat[7:0], wrap[0]);
    end
    step(1'b0, '0, '0, '0, 4'b0001, 4'b0001, 8'h00);
    checks++;
    if (ptr_flat[7:0] !== 8'd62 || wrap[0] !== 1'b0) begin
      errors++;
      $display("FAIL inc_dec_hold: ptr0=%0d wrap0=%b, required 62/0", ptr_flat[7:0], wrap[0]);
    end
    step(1'b0, '0, '0, '0, '0, 4'b0001, 8'h00);
    checks++;
    if (ptr_flat[7:0] !== 8'd61 || wrap[0] !== 1'b0) begin
      errors++;
      $display("FAIL dec_step: ptr0=%0d wrap0=%b, required 61/0", ptr_flat[7:0], wrap[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] w, lw, c, iv, dv;
      for (int i = 0; i < N; i++) begin
        w[i]  = ($urandom_range(0, 9) == 0);
        lw[i] = ($urandom_range(0, 9) == 0);
        c[i]  = ($urandom_range(0, 15) == 0);
        iv[i] = ($urandom_range(0, 3) != 0);
        dv[i] = ($urandom_range(0, 3) == 0);
      end
      Sel = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), w, lw, c, iv, dv, 8'($urandom_range(0, 15)));
      checks++;
      if (dout !== 8'(m_ptr[Sel])) begin
        errors++;
        $display("FAIL rand_dout k=%0d sel=%0d: got %0d, required %0d", k, Sel, dout, m_ptr[Sel]);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ptr_flat[i*W +: W] !== 8'(m_ptr[i]) || wrap[i] !== 1'(m_wrap[i]) ||
            at_lim[i] !== (m_ptr[i] == m_lim[i])) begin
          errors++;
          $display("FAIL rand k=%0d ch%0d: ptr=%0d wrap=%b at_lim=%b, required %0d/%0d/%0d",
                   k, i, ptr_flat[i*W +: W], wrap[i], at_lim[i], m_ptr[i], m_wrap[i],
                   (m_ptr[i] == m_lim[i]));
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; Wen = '0; LimWen = '0; CLR = '0; INC = '0; DEC = '0; BusOut = '0; Sel = '0;
    for (int i = 0; i < N; i++) begin
      m_ptr[i] = 0; m_lim[i] = MAXV; m_wrap[i] = 0;
    end
    test_reset();
    test_inc_full_range();
    test_limit_wrap();
    test_priority();
    test_above_limit_and_reset();
    test_all_channels();
`ifdef PTR_DEC_EN
    test_dec();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
